// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter/sequencer in front of the single-port dmemory32
// Optional per-port completion counters under DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_memWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_readData,
  output logic              busy,
  output logic              gnt_id
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       p0_cnt,
  output logic [15:0]       p1_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  stateT      state;
  stateT      stateNext;
  logic       latWe;
  logic       lastGnt;
  logic [2:0] waitCnt;
  logic       anyReq;
  logic       pickP1;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    anyReq    = p0_req | p1_req;
    // On contention the port that did not win last time gets the grant.
    pickP1    = p1_req & (~p0_req | ~lastGnt);
    case (state)
      IDLE:    if (anyReq) stateNext = ISSUE;
      ISSUE:   stateNext = latWe ? RESP : WAIT;
      WAIT:    if (waitCnt == 3'd1) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      latWe         <= 1'b0;
      lastGnt       <= 1'b1;
      waitCnt       <= 3'd0;
      gnt_id        <= 1'b0;
      mem_addr      <= '0;
      mem_writeData <= '0;
      p0_rdata      <= '0;
      p1_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            gnt_id        <= pickP1;
            latWe         <= pickP1 ? p1_we    : p0_we;
            mem_addr      <= pickP1 ? p1_addr  : p0_addr;
            mem_writeData <= pickP1 ? p1_wdata : p0_wdata;
          end
        end
        ISSUE: begin
          if (!latWe) waitCnt <= LAT;
        end
        WAIT: begin
          waitCnt <= waitCnt - 3'd1;
          if (waitCnt == 3'd1) begin
            if (gnt_id) p1_rdata <= mem_readData;
            else        p0_rdata <= mem_readData;
          end
        end
        RESP: lastGnt <= gnt_id;
        default: ;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      p0_cnt <= 16'd0;
      p1_cnt <= 16'd0;
    end else if (state == RESP) begin
      if (!gnt_id && p0_cnt != 16'hFFFF) p0_cnt <= p0_cnt + 16'd1;
      if (gnt_id && p1_cnt != 16'hFFFF)  p1_cnt <= p1_cnt + 16'd1;
    end
  end
`endif

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign mem_memWrite = (state == ISSUE) & latWe;
  assign p0_ack       = (state == RESP) & ~gnt_id;
  assign p1_ack       = (state == RESP) & gnt_id;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven bench for dmem_arbiter with a one-cycle-latency memory model
// Counter checks are compiled in when DMEM_ARB_PERF_EN is defined.
module tb_dmem_arbiter;

  localparam logic [31:0] A = 32'hA000_0000;
  localparam logic [31:0] F = 32'h0000_00F5;

  logic        clock = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack, mem_memWrite, busy, gnt_id;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_writeData, mem_readData;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] p0_cnt, p1_cnt;
`endif

  logic [31:0] memArr [0:255];
  logic [31:0] rdReg;

  int nCmp = 0;
  int nBad = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_memWrite(mem_memWrite), .mem_addr(mem_addr), .mem_writeData(mem_writeData),
    .mem_readData(mem_readData), .busy(busy), .gnt_id(gnt_id)
`ifdef DMEM_ARB_PERF_EN
    , .p0_cnt(p0_cnt), .p1_cnt(p1_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Memory samples the address on the edge closing ISSUE; data is valid one edge later.
  always @(posedge clock) begin
    if (mem_memWrite) memArr[mem_addr[7:0]] <= mem_writeData;
    rdReg <= memArr[mem_addr[7:0]];
  end
  assign mem_readData = rdReg;

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        eMw;
    logic [31:0] eAddr, eWd;
    logic        eAck0, eAck1, eBusy, eGnt;
    logic [31:0] eRd0, eRd1;
  } vecT;

  vecT vecs [24];

  function automatic vecT mk(logic rst, logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                             logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                             logic eMw, logic [31:0] eAddr, logic [31:0] eWd,
                             logic eAck0, logic eAck1, logic eBusy, logic eGnt,
                             logic [31:0] eRd0, logic [31:0] eRd1);
    vecT v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eMw = eMw; v.eAddr = eAddr; v.eWd = eWd;
    v.eAck0 = eAck0; v.eAck1 = eAck1; v.eBusy = eBusy; v.eGnt = eGnt;
    v.eRd0 = eRd0; v.eRd1 = eRd1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic eMw, input logic [31:0] eAddr,
                          input logic [31:0] eWd, input logic eAck0, input logic eAck1,
                          input logic eBusy, input logic eGnt, input logic [31:0] eRd0,
                          input logic [31:0] eRd1);
    check({tag, ".memWrite"}, 32'(mem_memWrite), 32'(eMw));
    check({tag, ".addr"},     mem_addr, eAddr);
    check({tag, ".wdata"},    mem_writeData, eWd);
    check({tag, ".ack0"},     32'(p0_ack), 32'(eAck0));
    check({tag, ".ack1"},     32'(p1_ack), 32'(eAck1));
    check({tag, ".busy"},     32'(busy), 32'(eBusy));
    check({tag, ".gnt"},      32'(gnt_id), 32'(eGnt));
    check({tag, ".rdata0"},   p0_rdata, eRd0);
    check({tag, ".rdata1"},   p1_rdata, eRd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) memArr[i] = 32'd0;
    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;

    //            rst r0 w0 a0     d0 r1 w1 a1     d1 | mw addr   wd  a0 a1 bz g  rd0 rd1
    vecs[0]  = mk(1, 0, 0, 0,     0, 0, 0, 0,     0,   0, 0,     0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 32'h10, A, 0, 0, 0,     0,   1, 32'h10, A, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 32'h10, A, 0, 0, 0,     0,   0, 32'h10, A, 1, 0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 1, 1, 32'h10, A, 0, 0, 0,     0,   0, 32'h10, A, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0,     0, 0, 0, 0,     0,   0, 32'h10, A, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 0, 32'h10, 0, 0, 0, 0,     0,   0, 32'h10, 0, 0, 0, 1, 0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 32'h10, 0, 0, 0, 0,     0,   0, 32'h10, 0, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 32'h10, 0, 0, 0, 0,     0,   0, 32'h10, 0, 1, 0, 1, 0, A, 0);
    vecs[8]  = mk(0, 1, 0, 32'h10, 0, 0, 0, 0,     0,   0, 32'h10, 0, 0, 0, 0, 0, A, 0);
    vecs[9]  = mk(1, 0, 0, 0,     0, 0, 0, 0,     0,   0, 0,     0,  0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  0, 32'h10, 0, 0, 0, 1, 0, 0, 0);
    vecs[11] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  0, 32'h10, 0, 0, 0, 1, 0, 0, 0);
    vecs[12] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  0, 32'h10, 0, 1, 0, 1, 0, A, 0);
    vecs[13] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  0, 32'h10, 0, 0, 0, 0, 0, A, 0);
    vecs[14] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  1, 32'h20, F, 0, 0, 1, 1, A, 0);
    vecs[15] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  0, 32'h20, F, 0, 1, 1, 1, A, 0);
    vecs[16] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  0, 32'h20, F, 0, 0, 0, 1, A, 0);
    vecs[17] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  0, 32'h10, 0, 0, 0, 1, 0, A, 0);
    vecs[18] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  0, 32'h10, 0, 0, 0, 1, 0, A, 0);
    vecs[19] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  0, 32'h10, 0, 1, 0, 1, 0, A, 0);
    vecs[20] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  0, 32'h10, 0, 0, 0, 0, 0, A, 0);
    vecs[21] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  1, 32'h20, F, 0, 0, 1, 1, A, 0);
    vecs[22] = mk(0, 1, 0, 32'h10, 0, 1, 1, 32'h20, F,  0, 32'h20, F, 0, 1, 1, 1, A, 0);
    vecs[23] = mk(0, 0, 0, 0,     0, 0, 0, 0,     0,   0, 32'h20, F, 0, 0, 0, 1, A, 0);

    for (int i = 0; i < 24; i++) begin
      reset = vecs[i].rst;
      p0_req = vecs[i].r0; p0_we = vecs[i].w0; p0_addr = vecs[i].a0; p0_wdata = vecs[i].d0;
      p1_req = vecs[i].r1; p1_we = vecs[i].w1; p1_addr = vecs[i].a1; p1_wdata = vecs[i].d1;
      tick();
      checkAll($sformatf("row%0d", i), vecs[i].eMw, vecs[i].eAddr, vecs[i].eWd,
               vecs[i].eAck0, vecs[i].eAck1, vecs[i].eBusy, vecs[i].eGnt,
               vecs[i].eRd0, vecs[i].eRd1);
    end
    check("mem20", memArr[8'h20], F);

`ifdef DMEM_ARB_PERF_EN
    check("p0Cnt", 32'(p0_cnt), 32'd2);
    check("p1Cnt", 32'(p1_cnt), 32'd2);
`endif

    // Back-to-back: p1 swaps address during its ack and keeps req high.
    p1_req = 1; p1_we = 1; p1_addr = 32'h30; p1_wdata = 32'h11;
    tick(); checkAll("b2bIssue1", 1, 32'h30, 32'h11, 0, 0, 1, 1, A, 0);
    tick(); checkAll("b2bResp1",  0, 32'h30, 32'h11, 0, 1, 1, 1, A, 0);
    p1_addr = 32'h34; p1_wdata = 32'h22;
    tick(); checkAll("b2bIdle",   0, 32'h30, 32'h11, 0, 0, 0, 1, A, 0);
    tick(); checkAll("b2bIssue2", 1, 32'h34, 32'h22, 0, 0, 1, 1, A, 0);
    tick(); checkAll("b2bResp2",  0, 32'h34, 32'h22, 0, 1, 1, 1, A, 0);
    p1_req = 0;
    tick(); checkAll("b2bDone",   0, 32'h34, 32'h22, 0, 0, 0, 1, A, 0);
    tick(); checkAll("b2bQuiet",  0, 32'h34, 32'h22, 0, 0, 0, 1, A, 0);
    check("mem30", memArr[8'h30], 32'h11);
    check("mem34", memArr[8'h34], 32'h22);

    // Reset during WAIT aborts the read with no ack.
    p0_req = 1; p0_we = 0; p0_addr = 32'h34; p0_wdata = 0;
    tick(); checkAll("rstIssue", 0, 32'h34, 0, 0, 0, 1, 0, A, 0);
    tick(); checkAll("rstWait",  0, 32'h34, 0, 0, 0, 1, 0, A, 0);
    reset = 1; p0_req = 0;
    tick(); checkAll("rstClear", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); checkAll($sformatf("rstIdle%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // A following p1 read completes with the usual T0+3 latency.
    p1_req = 1; p1_we = 0; p1_addr = 32'h30; p1_wdata = 0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (p1_ack) begin
        n = k;
        break;
      end
    end
    check("postRstLatency", 32'(n), 32'd3);
    check("postRstRdata", p1_rdata, 32'h11);
    p1_req = 0;
    tick(); tick();
    checkAll("postRstHold", 0, 32'h30, 0, 0, 0, 0, 1, 0, 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (dmemory32).
- Port 0 is the CPU load/store path; port 1 is a secondary master (UART program loader / IO DMA).
- Serialises accesses, drives the memory's memWrite/addr/writeData, waits out the read latency, and returns read data with a one-cycle ack.
- Round-robin arbitration so neither master starves.

Parameters:
- ADDR_W, 32, address width passed to memory
- DATA_W, 32, data width
- RD_LAT, 1, clock edges from the memory sampling the address to readData being valid (legal range 1..7)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- p0_req  in  1  port 0 request, level; held until p0_ack
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_W  port 0 address
- p0_wdata  in  DATA_W  port 0 write data
- p0_ack  out  1  one-cycle completion pulse for port 0
- p0_rdata  out  DATA_W  port 0 read data, valid while p0_ack=1 and held afterwards
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1
- mem_memWrite  out  1  to memory memWrite
- mem_addr  out  ADDR_W  to memory address
- mem_writeData  out  DATA_W  to memory writeData
- mem_readData  in  DATA_W  from memory readData
- busy  out  1  high in any state other than IDLE
- gnt_id  out  1  port owning the current or last transaction

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including the rdata registers.
  - The round-robin pointer favours port 0.
  - The wait counter clears.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select a winner, latch its we/addr/wdata and gnt_id, then go to ISSUE next cycle.
  - If only one req is high, that port wins.
  - If both are high, the port not granted last wins; after reset this is port 0.
- ISSUE (exactly 1 cycle):
  - mem_addr and mem_writeData carry the latched values.
  - mem_memWrite equals the latched we; it is high only in this state.
  - Write: next state is RESP.
  - Read: load the counter with RD_LAT and go to WAIT.
- WAIT:
  - mem_addr is held and the counter decrements each cycle.
  - In the cycle where the counter equals 1, capture mem_readData into the winner's rdata register at the closing edge, then go to RESP.
  - WAIT lasts exactly RD_LAT cycles.
- RESP (1 cycle):
  - The winner's ack is 1; the other ack is 0.
  - Update the round-robin pointer to the winner. Next state is IDLE.
- Latency from req sampled in IDLE at T0:
  - Write: ack at T0+2.
  - Read: ack at T0+2+RD_LAT.
  - Throughput is one transaction per (3 + RD_LAT·read) cycles.
- Requesters drop req in the cycle after ack. A req still high in IDLE after RESP is a new transaction (back-to-back allowed, arbitrated normally).
- req/we/addr/wdata changes after the IDLE sample are ignored until the next IDLE.
- Write transactions do not modify rdata registers.
- mem_addr and mem_writeData keep their last values in IDLE and RESP; mem_memWrite is 0 there.
- Reset mid-transaction: the transaction is aborted and no ack is issued. If reset asserts in ISSUE, mem_memWrite still shows the latched we in that cycle; the memory write may occur and is not undone.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN
- With the macro defined:
  - Adds outputs p0_cnt and p1_cnt, each 16 bits.
  - Each counts completed transactions (RESP cycles) for its port, saturating at 16'hFFFF.
  - Both clear on reset.
- Without the macro: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single write: reset, then p0 write to addr 32'h10, data 32'hA000_0000. Expect mem_memWrite=1 for exactly one cycle with addr 32'h10 and data 32'hA000_0000, then p0_ack at T0+2.
- Single read: p0 read of 32'h10 with the memory model returning 32'hA000_0000 after RD_LAT=1. Expect p0_ack at T0+3 with p0_rdata=32'hA000_0000 and no mem_memWrite pulse.
- Contention: p0 and p1 both request in the same cycle after reset (p0 read 32'h10, p1 write 32'h20 data 32'h0000_00F5). Expect p0 granted first, then p1. With both still requesting, grants alternate 0,1,0,1.
- Back-to-back: p1 keeps req high with a new address after ack. Expect a new ISSUE 2 cycles after RESP and no lost or duplicated ack.
- Reset mid-read: reset asserted in WAIT. Expect no ack, state IDLE, and all outputs 0 the next cycle; a following p1 read completes normally.
- With DMEM_ARB_PERF_EN defined, after the contention test: p0_cnt and p1_cnt equal the number of completed acks per port.
